// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Request/grant and memory-bus signals between two masters and the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              p0Req;
    logic              p0Gnt;
    logic              p0memEnable;
    logic              p0memWrite;
    logic [ADDR_W-1:0] p0memAddr;
    logic [DATA_W-1:0] p0memDataW;

    logic              p1Req;
    logic              p1Gnt;
    logic              p1memEnable;
    logic              p1memWrite;
    logic [ADDR_W-1:0] p1memAddr;
    logic [DATA_W-1:0] p1memDataW;

    logic              memEnable;
    logic              memWrite;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataW;
    logic [1:0]        busOwner;
    logic              preemptPulse;
    logic [15:0]       grantCount0;
    logic [15:0]       grantCount1;

    // Arbiter side
    modport slave (
        input  p0Req, p0memEnable, p0memWrite, p0memAddr, p0memDataW,
        input  p1Req, p1memEnable, p1memWrite, p1memAddr, p1memDataW,
        output p0Gnt, p1Gnt,
        output memEnable, memWrite, memAddr, memDataW,
        output busOwner, preemptPulse, grantCount0, grantCount1
    );

    // Processor / environment side
    modport master (
        output p0Req, p0memEnable, p0memWrite, p0memAddr, p0memDataW,
        output p1Req, p1memEnable, p1memWrite, p1memAddr, p1memDataW,
        input  p0Gnt, p1Gnt,
        input  memEnable, memWrite, memAddr, memDataW,
        input  busOwner, preemptPulse, grantCount0, grantCount1
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Round-robin two-master memory bus arbiter with optional hold-time
//            preemption. Define ARB_STATS_EN to build the grant counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  wire logic           CLK,
    input  wire logic           RESET,
    mem_bus_arbiter_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    localparam int          HOLD_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = PREEMPT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;     // 1 = master 1 owned last
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              preempt_q, preempt_d;

    logic              own_id;
    logic              own_req;
    logic              oth_req;

    assign own_id  = (state_q == S_OWN1);
    assign own_req = own_id ? bus.p1Req : bus.p0Req;
    assign oth_req = own_id ? bus.p0Req : bus.p1Req;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                hold_d = '0;
                if (bus.p0Req && bus.p1Req) begin
                    state_d = last_q ? S_OWN0 : S_OWN1;
                end else if (bus.p0Req) begin
                    state_d = S_OWN0;
                end else if (bus.p1Req) begin
                    state_d = S_OWN1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (!own_req) begin
                    state_d = S_IDLE;
                    last_d  = own_id;
                    hold_d  = '0;
                end else if (PREEMPT_EN && oth_req && (hold_q == HOLD_LAST)) begin
                    state_d   = own_id ? S_OWN0 : S_OWN1;
                    last_d    = own_id;
                    hold_d    = '0;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Bus mux: only the owner's strobes reach the memory controller.
    always_comb begin
        bus.p0Gnt        = (state_q == S_OWN0);
        bus.p1Gnt        = (state_q == S_OWN1);
        bus.busOwner     = {(state_q == S_OWN1), (state_q == S_OWN0)};
        bus.preemptPulse = preempt_q;
        bus.memEnable    = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddr      = {ADDR_W{1'b0}};
        bus.memDataW     = {DATA_W{1'b0}};
        if (state_q == S_OWN0) begin
            bus.memEnable = bus.p0memEnable;
            bus.memWrite  = bus.p0memWrite;
            bus.memAddr   = bus.p0memAddr;
            bus.memDataW  = bus.p0memDataW;
        end else if (state_q == S_OWN1) begin
            bus.memEnable = bus.p1memEnable;
            bus.memWrite  = bus.p1memWrite;
            bus.memAddr   = bus.p1memAddr;
            bus.memDataW  = bus.p1memDataW;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if ((state_d == S_OWN0) && (state_q != S_OWN0) && (cnt0_q != 16'hFFFF)) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if ((state_d == S_OWN1) && (state_q != S_OWN1) && (cnt1_q != 16'hFFFF)) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    always_comb begin
        bus.grantCount0 = cnt0_q;
        bus.grantCount1 = cnt1_q;
    end
`else
    always_comb begin
        bus.grantCount0 = 16'd0;
        bus.grantCount1 = 16'd0;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench for mem_bus_arbiter with MAX_HOLD=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
    logic CLK;
    logic RESET;
    int   n_total;
    int   n_bad;
    int   g0;
    int   g1;

    mem_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_bus_arbiter #(
        .MAX_HOLD (4),
        .ADDR_W   (16),
        .DATA_W   (16)
    ) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int g);
`ifdef ARB_STATS_EN
        return 32'(g);
`else
        return 32'(g * 0);
`endif
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        g0 = 0;
        g1 = 0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        g0      = 0;
        g1      = 0;
        bus.p0Req = 1'b0; bus.p0memEnable = 1'b0; bus.p0memWrite = 1'b0;
        bus.p0memAddr = 16'h0; bus.p0memDataW = 16'h0;
        bus.p1Req = 1'b0; bus.p1memEnable = 1'b0; bus.p1memWrite = 1'b0;
        bus.p1memAddr = 16'h0; bus.p1memDataW = 16'h0;

        // Reset state
        do_reset();
        check_eq("rst_owner",   32'(bus.busOwner), 32'h0);
        check_eq("rst_gnt",     32'({bus.p1Gnt, bus.p0Gnt}), 32'h0);
        check_eq("rst_preempt", 32'(bus.preemptPulse), 32'h0);
        check_eq("rst_en",      32'(bus.memEnable), 32'h0);
        check_eq("rst_cnt0",    32'(bus.grantCount0), 32'h0);
        check_eq("rst_cnt1",    32'(bus.grantCount1), 32'h0);

        // Single master 0 request, master 1 strobing without request
        bus.p0Req = 1'b1; bus.p0memEnable = 1'b1; bus.p0memWrite = 1'b1;
        bus.p0memAddr = 16'h0123; bus.p0memDataW = 16'hBEEF;
        bus.p1memEnable = 1'b1; bus.p1memWrite = 1'b0; bus.p1memAddr = 16'h0456;
        bus.p1memDataW = 16'h5555;
        #1;
        check_eq("pre_gnt_idle_en", 32'(bus.memEnable), 32'h0);
        check_eq("pre_gnt_p0gnt",   32'(bus.p0Gnt), 32'h0);
        tick();
        g0 = g0 + 1;
        check_eq("t1_owner", 32'(bus.busOwner), 32'h1);
        check_eq("t1_p0gnt", 32'(bus.p0Gnt), 32'h1);
        check_eq("t1_p1gnt", 32'(bus.p1Gnt), 32'h0);
        check_eq("t1_addr",  32'(bus.memAddr), 32'h0123);
        check_eq("t1_data",  32'(bus.memDataW), 32'hBEEF);
        check_eq("t1_wr",    32'(bus.memWrite), 32'h1);
        check_eq("t1_en",    32'(bus.memEnable), 32'h1);
        bus.p0memEnable = 1'b0;
        #1;
        check_eq("t1_en_gated", 32'(bus.memEnable), 32'h0);
        bus.p0Req = 1'b0;
        tick();
        check_eq("t1_idle_owner", 32'(bus.busOwner), 32'h0);
        check_eq("t1_idle_addr",  32'(bus.memAddr), 32'h0);
        check_eq("t1_idle_wr",    32'(bus.memWrite), 32'h0);
        bus.p1memEnable = 1'b0;

        // Round robin: simultaneous requests after reset
        do_reset();
        bus.p0Req = 1'b1; bus.p1Req = 1'b1;
        tick();
        g0 = g0 + 1;
        check_eq("rr_first_owner", 32'(bus.busOwner), 32'h1);
        tick();
        check_eq("rr_hold_owner", 32'(bus.busOwner), 32'h1);
        bus.p0Req = 1'b0;
        tick();
        check_eq("rr_gap_idle", 32'(bus.busOwner), 32'h0);
        tick();
        g1 = g1 + 1;
        check_eq("rr_second_owner", 32'(bus.busOwner), 32'h2);
        check_eq("rr_second_p1gnt", 32'(bus.p1Gnt), 32'h1);
        bus.p0Req = 1'b1; bus.p1Req = 1'b0;
        tick();
        check_eq("rr_gap2_idle", 32'(bus.busOwner), 32'h0);
        bus.p1Req = 1'b1;
        tick();
        g0 = g0 + 1;
        check_eq("rr_third_owner", 32'(bus.busOwner), 32'h1);
        check_eq("rr_third_p1gnt", 32'(bus.p1Gnt), 32'h0);

        // Preemption: master 0 has owned one cycle, master 1 waiting
        tick();
        check_eq("pe_c2_owner", 32'(bus.busOwner), 32'h1);
        tick();
        check_eq("pe_c3_owner", 32'(bus.busOwner), 32'h1);
        tick();
        check_eq("pe_c4_owner",   32'(bus.busOwner), 32'h1);
        check_eq("pe_c4_preempt", 32'(bus.preemptPulse), 32'h0);
        tick();
        g1 = g1 + 1;
        check_eq("pe_p0gnt_drop", 32'(bus.p0Gnt), 32'h0);
        check_eq("pe_p1gnt_rise", 32'(bus.p1Gnt), 32'h1);
        check_eq("pe_pulse",      32'(bus.preemptPulse), 32'h1);
        tick();
        check_eq("pe_pulse_end",  32'(bus.preemptPulse), 32'h0);
        check_eq("pe_still_p1",   32'(bus.busOwner), 32'h2);
        bus.p0Req = 1'b0; bus.p1Req = 1'b0;
        tick();
        check_eq("pe_release", 32'(bus.busOwner), 32'h0);

        // Long tenure with no competitor: never preempted
        bus.p0Req = 1'b1;
        tick();
        g0 = g0 + 1;
        for (int i = 0; i < 20; i++) begin
            check_eq("nopre_owner", 32'(bus.busOwner), 32'h1);
            check_eq("nopre_pulse", 32'(bus.preemptPulse), 32'h0);
            tick();
        end
        check_eq("stats_cnt0", 32'(bus.grantCount0), exp_cnt(g0));
        check_eq("stats_cnt1", 32'(bus.grantCount1), exp_cnt(g1));
        bus.p0Req = 1'b0;
        tick();

        // Reset in the middle of a master 1 write tenure
        bus.p1Req = 1'b1; bus.p1memWrite = 1'b1; bus.p1memEnable = 1'b1;
        tick();
        g1 = g1 + 1;
        check_eq("mr_pre_wr",    32'(bus.memWrite), 32'h1);
        check_eq("mr_pre_owner", 32'(bus.busOwner), 32'h2);
        RESET = 1'b1;
        tick();
        check_eq("mr_en",    32'(bus.memEnable), 32'h0);
        check_eq("mr_wr",    32'(bus.memWrite), 32'h0);
        check_eq("mr_p1gnt", 32'(bus.p1Gnt), 32'h0);
        check_eq("mr_owner", 32'(bus.busOwner), 32'h0);
        check_eq("mr_cnt1",  32'(bus.grantCount1), 32'h0);
        RESET = 1'b0;
        bus.p1Req = 1'b0; bus.p1memWrite = 1'b0; bus.p1memEnable = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
